// File: rtl/fwd_hazard_ctrl_pkg.sv
// Purpose: shared bypass-select encodings and mult/div timer states for the hazard controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pipe_hazard_pkg;

  // Bypass select encodings driven onto fwd_sel per EX source operand.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Mult/div timer states.
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } mdState_e;

  // Priority pick for one operand: the younger MEM result shadows WB.
  function automatic logic [1:0] fwdPick(input logic memHit, input logic wbHit);
    if (memHit) begin
      return FWD_MEM;
    end
    if (wbHit) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Purpose: bundles the pipeline-side inputs and control outputs of the hazard controller.
// Latency: n/a (wiring only).
// Backpressure: n/a; stall outputs are the only throttle.
interface fwd_hazard_ctrl_if #(
  parameter int AW   = 5,
  parameter int NSRC = 2,
  parameter int SCW  = 16
);
  // Pipeline observation
  logic [NSRC*AW-1:0] src_ex;
  logic [NSRC*AW-1:0] src_id;
  logic [NSRC-1:0]    src_id_vld;
  logic               ex_memrd;
  logic [AW-1:0]      ex_dst;
  logic               mem_regwr;
  logic [AW-1:0]      mem_dst;
  logic               wb_regwr;
  logic [AW-1:0]      wb_dst;
  logic               md_start;
  logic               id_uses_md;
  // Control results
  logic [2*NSRC-1:0]  fwd_sel;
  logic               stall_if;
  logic               stall_id;
  logic               flush_ex;
  logic               md_busy;
  logic [SCW-1:0]     stall_cnt;

  // Pipeline side: drives observations, consumes controls.
  modport master (
    output src_ex, src_id, src_id_vld, ex_memrd, ex_dst,
           mem_regwr, mem_dst, wb_regwr, wb_dst, md_start, id_uses_md,
    input  fwd_sel, stall_if, stall_id, flush_ex, md_busy, stall_cnt
  );

  // Controller side.
  modport slave (
    input  src_ex, src_id, src_id_vld, ex_memrd, ex_dst,
           mem_regwr, mem_dst, wb_regwr, wb_dst, md_start, id_uses_md,
    output fwd_sel, stall_if, stall_id, flush_ex, md_busy, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl_md_busy_timer.sv
// Purpose: tracks an in-flight multi-cycle mult/div; busy for exactly MD_LAT cycles after launch.
// Latency: busy rises the cycle after md_start is sampled, falls MD_LAT cycles later.
// Backpressure: none; a launch while busy simply restarts the full count.
module md_busy_timer
  import pipe_hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mdStart,
  output logic busy
);

  localparam int            CW   = $clog2(MD_LAT + 1);
  localparam logic [CW-1:0] LOAD = CW'(MD_LAT);
  localparam logic [CW-1:0] LAST = CW'(1);

  mdState_e      state, stateNxt;
  logic [CW-1:0] cnt, cntNxt;

  // State and remaining-cycle register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  // Next state: load on launch, count down while busy, drop out when the count hits zero.
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    case (state)
      MD_IDLE: begin
        if (mdStart) begin
          stateNxt = MD_BUSY;
          cntNxt   = LOAD;
        end
      end
      MD_BUSY: begin
        if (mdStart) begin
          cntNxt = LOAD;
        end else begin
          cntNxt = cnt - 1'b1;
          if (cnt == LAST) begin
            stateNxt = MD_IDLE;
          end
        end
      end
      default: begin
        stateNxt = MD_IDLE;
        cntNxt   = '0;
      end
    endcase
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Purpose: EX operand bypass selection plus load-use and mult/div stall generation.
// Latency: forwarding and stalls are combinational (0 cycles); stall_cnt updates on the stalled edge.
// Backpressure: stall_if/stall_id hold the front end and flush_ex bubbles EX for one cycle per hazard cycle.
module fwd_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int AW     = 5,
  parameter int NSRC   = 2,
  parameter int MD_LAT = 4,
  parameter int SCW    = 16
) (
  input logic clk,
  input logic rst_n,
  fwd_hazard_ctrl_if.slave hz
);

  logic [2*NSRC-1:0] fwdSel;
  logic [NSRC-1:0]   idLoadHit;
  logic              memLive, wbLive, exLoad;
  logic              loadUse, mdHazard, stall;
  logic              mdBusy;
  logic [SCW-1:0]    stallCnt;

  // Register 0 is hard-wired, so a write to it never produces a bypass or hazard.
  assign memLive = hz.mem_regwr && (hz.mem_dst != '0);
  assign wbLive  = hz.wb_regwr  && (hz.wb_dst  != '0);
  assign exLoad  = hz.ex_memrd  && (hz.ex_dst  != '0);

  for (genvar i = 0; i < NSRC; i++) begin : gSrc
    logic [AW-1:0] srcEx, srcId;
    assign srcEx        = hz.src_ex[i*AW +: AW];
    assign srcId        = hz.src_id[i*AW +: AW];
    assign fwdSel[2*i +: 2] = fwdPick(memLive && (srcEx == hz.mem_dst),
                                      wbLive  && (srcEx == hz.wb_dst));
    // Only operands the ID instruction really reads can create a load-use stall.
    assign idLoadHit[i] = hz.src_id_vld[i] && exLoad && (srcId == hz.ex_dst);
  end

  md_busy_timer #(
    .MD_LAT (MD_LAT)
  ) uMdTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .mdStart (hz.md_start),
    .busy    (mdBusy)
  );

  // A launch this cycle counts as busy for the ID instruction so it cannot slip past.
  assign loadUse  = |idLoadHit;
  assign mdHazard = hz.id_uses_md && (mdBusy || hz.md_start);
  assign stall    = rst_n && (loadUse || mdHazard);

  // Saturating count of stalled edges; holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (stall && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign hz.fwd_sel   = rst_n ? fwdSel : '0;
  assign hz.stall_if  = stall;
  assign hz.stall_id  = stall;
  assign hz.flush_ex  = stall;
  assign hz.md_busy   = mdBusy;
  assign hz.stall_cnt = stallCnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Purpose: directed scoreboard bench for fwd_hazard_ctrl (MD_LAT=4, SCW=4 build).
// Latency: checks comb outputs 3 time units after each rising edge.
// Backpressure: n/a.
module tb_fwd_hazard_ctrl;
  localparam int AW     = 5;
  localparam int NSRC   = 2;
  localparam int MD_LAT = 4;
  localparam int SCW    = 4;
  localparam int SMAX   = (1 << SCW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.AW(AW), .NSRC(NSRC), .SCW(SCW)) hz ();

  fwd_hazard_ctrl #(
    .AW(AW), .NSRC(NSRC), .MD_LAT(MD_LAT), .SCW(SCW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  string       tagQ[$];
  logic [31:0] expQ[$];
  int          nChecks = 0;
  int          nPass   = 0;
  int          scnt    = 0;
  bit          expStall = 1'b0;

  task automatic push(input string t, input logic [31:0] v);
    tagQ.push_back(t);
    expQ.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    nChecks++;
    if (expQ.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
      return;
    end
    t = tagQ.pop_front();
    e = expQ.pop_front();
    assert (obs === e) nPass++;
    else $error("FAIL %s: observed %0h expected %0h", t, obs, e);
  endtask

  task automatic clearIn();
    hz.src_ex = '0; hz.src_id = '0; hz.src_id_vld = '0;
    hz.ex_memrd = 1'b0; hz.ex_dst = '0;
    hz.mem_regwr = 1'b0; hz.mem_dst = '0;
    hz.wb_regwr = 1'b0; hz.wb_dst = '0;
    hz.md_start = 1'b0; hz.id_uses_md = 1'b0;
  endtask

  // Advance to just after the next rising edge, updating the stall-count model.
  task automatic nextCyc();
    @(posedge clk);
    if (expStall && scnt < SMAX) scnt++;
    #1;
  endtask

  task automatic expStallChk(input string t, input bit s);
    expStall = s;
    push(t, 32'({s, s, s}));
    #2;
    chk(32'({hz.stall_if, hz.stall_id, hz.flush_ex}));
  endtask

  task automatic cntChk(input string t);
    push(t, 32'(scnt));
    chk(32'(hz.stall_cnt));
  endtask

  task automatic busyChk(input string t, input bit b);
    push(t, 32'(b));
    chk(32'(hz.md_busy));
  endtask

  task automatic fwdChk(input string t, input logic [3:0] v);
    push(t, 32'(v));
    #1;
    chk(32'(hz.fwd_sel));
  endtask

  task automatic releaseReset();
    clearIn();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset: outputs forced quiet even with hazard-looking inputs.
    clearIn();
    hz.mem_regwr = 1'b1; hz.mem_dst = 5'd8; hz.src_ex = {5'd8, 5'd8};
    hz.id_uses_md = 1'b1; hz.md_start = 1'b1;
    #12;
    fwdChk("rst_fwd", 4'b0000);
    expStallChk("rst_stall", 1'b0);
    busyChk("rst_busy", 1'b0);
    cntChk("rst_cnt");
    releaseReset();

    // Forwarding priority.
    nextCyc();
    hz.mem_regwr = 1'b1; hz.mem_dst = 5'd8; hz.wb_regwr = 1'b1; hz.wb_dst = 5'd8;
    hz.src_ex = {5'd8, 5'd8};
    fwdChk("mem_over_wb", 4'b1010);
    hz.mem_regwr = 1'b0;
    fwdChk("wb_only", 4'b0101);
    hz.mem_regwr = 1'b1; hz.mem_dst = 5'd3; hz.src_ex = {5'd8, 5'd3};
    fwdChk("per_lane", 4'b0110);
    hz.mem_regwr = 1'b0; hz.wb_dst = 5'd0; hz.src_ex = {5'd0, 5'd0};
    fwdChk("wb_r0", 4'b0000);
    hz.mem_regwr = 1'b1; hz.mem_dst = 5'd0;
    fwdChk("mem_r0", 4'b0000);
    expStallChk("fwd_nostall", 1'b0);

    // Load-use hazard.
    nextCyc();
    clearIn();
    hz.ex_memrd = 1'b1; hz.ex_dst = 5'd5; hz.src_id = {5'd5, 5'd0}; hz.src_id_vld = 2'b10;
    expStallChk("lu_lane1", 1'b1);
    cntChk("lu_cnt0");
    nextCyc();
    clearIn();
    hz.mem_regwr = 1'b1; hz.mem_dst = 5'd5; hz.src_ex = {5'd5, 5'd0};
    expStallChk("lu_released", 1'b0);
    cntChk("lu_cnt1");
    fwdChk("lu_fwd_mem", 4'b1000);
    nextCyc();
    clearIn();
    hz.ex_memrd = 1'b1; hz.ex_dst = 5'd5; hz.src_id = {5'd5, 5'd0}; hz.src_id_vld = 2'b00;
    expStallChk("lu_not_read", 1'b0);
    hz.src_id = {5'd0, 5'd5}; hz.src_id_vld = 2'b01;
    expStallChk("lu_lane0", 1'b1);
    nextCyc();
    cntChk("lu_cnt2");
    hz.ex_dst = 5'd0; hz.src_id = '0; hz.src_id_vld = 2'b11;
    expStallChk("lu_r0", 1'b0);

    // Mult/div busy window with a coincident load-use cycle.
    rst_n = 1'b0; scnt = 0; expStall = 1'b0;
    releaseReset();
    nextCyc();
    hz.md_start = 1'b1; hz.id_uses_md = 1'b1;
    expStallChk("md_c0_stall", 1'b1);
    busyChk("md_c0_busy", 1'b0);
    for (int c = 1; c <= 5; c++) begin
      nextCyc();
      hz.md_start = 1'b0;
      if (c == 2) begin
        hz.ex_memrd = 1'b1; hz.ex_dst = 5'd9; hz.src_id = {5'd0, 5'd9}; hz.src_id_vld = 2'b01;
      end else begin
        hz.ex_memrd = 1'b0; hz.ex_dst = '0; hz.src_id = '0; hz.src_id_vld = '0;
      end
      expStallChk($sformatf("md_c%0d_stall", c), c <= 4);
      busyChk($sformatf("md_c%0d_busy", c), c <= 4);
    end
    cntChk("md_cnt5");

    // Relaunch while busy extends the window.
    nextCyc();
    clearIn();
    hz.md_start = 1'b1;
    expStallChk("rl_c0_stall", 1'b0);
    for (int c = 1; c <= 7; c++) begin
      nextCyc();
      hz.md_start = (c == 2);
      #2;
      busyChk($sformatf("rl_c%0d_busy", c), c <= 6);
    end

    // Asynchronous reset in the middle of a busy window.
    nextCyc();
    clearIn();
    hz.md_start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      nextCyc();
      hz.md_start = (c == 2);
    end
    #1;
    busyChk("ar_busy_before", 1'b1);
    hz.id_uses_md = 1'b1; hz.mem_regwr = 1'b1; hz.mem_dst = 5'd4; hz.src_ex = {5'd0, 5'd4};
    expStallChk("ar_stall_before", 1'b1);
    rst_n = 1'b0; scnt = 0; expStall = 1'b0;
    #1;
    busyChk("ar_busy_after", 1'b0);
    expStallChk("ar_stall_after", 1'b0);
    fwdChk("ar_fwd_after", 4'b0000);
    cntChk("ar_cnt_after");
    releaseReset();

    // Saturation: hold a load-use stall for 2^SCW+3 cycles.
    nextCyc();
    hz.ex_memrd = 1'b1; hz.ex_dst = 5'd7; hz.src_id = {5'd0, 5'd7}; hz.src_id_vld = 2'b01;
    for (int c = 0; c < (1 << SCW) + 3; c++) begin
      if (c > 0) nextCyc();
      expStallChk($sformatf("sat_c%0d_stall", c), 1'b1);
      cntChk($sformatf("sat_c%0d_cnt", c));
    end
    nextCyc();
    push("sat_final", 32'hF);
    chk(32'(hz.stall_cnt));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
